ctrl_fsm: RTL and testbench

Second-generation picoMIPS control unit: a clocked replacement for the purely combinational instruction decoder. Sits between program memory/opcode field and datapath (PC, register file, ALU, immediate mux). Adds a synchronised and debounced SW8 input, an optional multi-cycle multiplier handshake, an explicit register-file write enable, and a sticky illegal-opcode halt. Supports the existing instruction set: LIR, LSR, ADD, ADDI, MUL, MULI, WAIT0, WAIT1.

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/sw_debounce.sv | 51 +++++
 rtl/ctrl_fsm.sv | 145 ++++++++++++++
 tb/tb_ctrl_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared definitions for the picoMIPS control unit.
//               Defines the controller state enum, the instruction opcodes
//               and the ALU function codes.
// Revision    : 1.0 - initial clocked control unit
// ============================================================================
package ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    EXEC    = 2'd0,
    MULWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  // Instruction opcodes
  localparam logic [5:0] c_OP_LIR   = 6'h01;
  localparam logic [5:0] c_OP_LSR   = 6'h02;
  localparam logic [5:0] c_OP_ADD   = 6'h03;
  localparam logic [5:0] c_OP_ADDI  = 6'h04;
  localparam logic [5:0] c_OP_MUL   = 6'h05;
  localparam logic [5:0] c_OP_MULI  = 6'h06;
  localparam logic [5:0] c_OP_WAIT0 = 6'h07;
  localparam logic [5:0] c_OP_WAIT1 = 6'h08;

  // ALU function codes
  localparam logic [1:0] c_RA   = 2'd0;
  localparam logic [1:0] c_RB   = 2'd1;
  localparam logic [1:0] c_RADD = 2'd2;
  localparam logic [1:0] c_RMUL = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Two-flop synchroniser followed by a level debouncer for a
//               raw mechanical switch.
// Ports       : clk       - system clock, rising edge
//               reset     - asynchronous active-high reset
//               sw_i      - raw asynchronous switch input
//               sw_stable - debounced, synchronised switch level (reset 0)
// Revision    : 1.0 - initial version
// ============================================================================
module sw_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic sw_stable
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          w_sync;

  assign w_sync    = sync_q[1];
  assign sw_stable = stable_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= 2'b00;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      if (w_sync == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        // This edge is the DEB_CYCLES-th consecutive differing sample.
        stable_q <= w_sync;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fsm
// Description : Clocked picoMIPS control unit. Decodes the opcode into
//               datapath controls, waits on SW8 for WAIT0/WAIT1, optionally
//               handshakes with a multi-cycle multiplier and halts stickily
//               on an undefined opcode.
// Ports       : clk         - system clock, rising edge
//               reset       - asynchronous active-high reset
//               opcode      - current instruction opcode
//               SW8         - raw switch input
//               mul_done    - multiplier result valid (MULWAIT only)
//               PCincr      - PC advance enable
//               ALUfunc     - ALU operation select
//               imm         - B operand is the immediate
//               immswitches - immediate comes from the switches
//               reg_we      - register file write enable
//               mul_start   - one-cycle multiplier start pulse
//               illegal     - sticky illegal-opcode flag
// Revision    : 1.0 - initial clocked control unit
// ============================================================================
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int O_SIZE     = 6,
  parameter int A_SIZE     = 2,
  parameter int DEB_CYCLES = 4,
  parameter int MUL_MC     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [O_SIZE-1:0] opcode,
  input  logic              SW8,
  input  logic              mul_done,
  output logic              PCincr,
  output logic [A_SIZE-1:0] ALUfunc,
  output logic              imm,
  output logic              immswitches,
  output logic              reg_we,
  output logic              mul_start,
  output logic              illegal
);

  state_t state_q;
  state_t state_d;
  logic   w_sw_stable;
  logic   w_is_mul;
  logic   w_is_muli;

  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sw_debounce (
    .clk      (clk),
    .reset    (reset),
    .sw_i     (SW8),
    .sw_stable(w_sw_stable)
  );

  assign w_is_muli = (opcode == O_SIZE'(c_OP_MULI));
  assign w_is_mul  = (opcode == O_SIZE'(c_OP_MUL)) || w_is_muli;

  // HALT is only reachable through an illegal opcode and is left only by
  // reset, so the sticky flag is simply the state itself.
  assign illegal = (state_q == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EXEC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    PCincr      = 1'b0;
    ALUfunc     = A_SIZE'(c_RA);
    imm         = 1'b0;
    immswitches = 1'b0;
    reg_we      = 1'b0;
    mul_start   = 1'b0;
    // While reset is high every output stays at its default.
    if (!reset) begin
      case (state_q)
        EXEC: begin
          if (opcode == O_SIZE'(c_OP_LIR)) begin
            ALUfunc = A_SIZE'(c_RB);
            imm     = 1'b1;
            reg_we  = 1'b1;
            PCincr  = 1'b1;
          end else if (opcode == O_SIZE'(c_OP_LSR)) begin
            ALUfunc     = A_SIZE'(c_RB);
            imm         = 1'b1;
            immswitches = 1'b1;
            reg_we      = w_sw_stable;
            PCincr      = w_sw_stable;
          end else if (opcode == O_SIZE'(c_OP_ADD)) begin
            ALUfunc = A_SIZE'(c_RADD);
            reg_we  = 1'b1;
            PCincr  = 1'b1;
          end else if (opcode == O_SIZE'(c_OP_ADDI)) begin
            ALUfunc = A_SIZE'(c_RADD);
            imm     = 1'b1;
            reg_we  = 1'b1;
            PCincr  = 1'b1;
          end else if (opcode == O_SIZE'(c_OP_WAIT0)) begin
            PCincr = ~w_sw_stable;
          end else if (opcode == O_SIZE'(c_OP_WAIT1)) begin
            PCincr = w_sw_stable;
          end else if (w_is_mul) begin
            ALUfunc = A_SIZE'(c_RMUL);
            imm     = w_is_muli;
            if (MUL_MC != 0) begin
              // Write-back and PC advance wait for mul_done in MULWAIT.
              mul_start = 1'b1;
              state_d   = MULWAIT;
            end else begin
              reg_we = 1'b1;
              PCincr = 1'b1;
            end
          end else begin
            state_d = HALT;
          end
        end
        MULWAIT: begin
          ALUfunc = A_SIZE'(c_RMUL);
          imm     = w_is_muli;
          if (mul_done) begin
            reg_we  = 1'b1;
            PCincr  = 1'b1;
            state_d = EXEC;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = EXEC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_fsm
// Description : Scoreboard bench for ctrl_fsm. Two instances share inputs:
//               one with a multi-cycle multiplier, one single-cycle.
//               Output vector: {PCincr, ALUfunc[1:0], imm, immswitches,
//               reg_we, mul_start, illegal}.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_ctrl_fsm;

  localparam logic [5:0] LIR   = 6'h01;
  localparam logic [5:0] LSR   = 6'h02;
  localparam logic [5:0] ADD   = 6'h03;
  localparam logic [5:0] ADDI  = 6'h04;
  localparam logic [5:0] MUL   = 6'h05;
  localparam logic [5:0] MULI  = 6'h06;
  localparam logic [5:0] WAIT0 = 6'h07;
  localparam logic [5:0] WAIT1 = 6'h08;
  localparam logic [5:0] BADOP = 6'h3F;

  localparam logic [1:0] RA   = 2'd0;
  localparam logic [1:0] RB   = 2'd1;
  localparam logic [1:0] RADD = 2'd2;
  localparam logic [1:0] RMUL = 2'd3;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       SW8;
  logic       mul_done;

  logic       pc_mc, imm_mc, ims_mc, we_mc, ms_mc, ill_mc;
  logic [1:0] alu_mc;
  logic       pc_sc, imm_sc, ims_sc, we_sc, ms_sc, ill_sc;
  logic [1:0] alu_sc;

  ctrl_fsm #(.O_SIZE(6), .A_SIZE(2), .DEB_CYCLES(4), .MUL_MC(1)) dut_mc (
    .clk(clk), .reset(reset), .opcode(opcode), .SW8(SW8), .mul_done(mul_done),
    .PCincr(pc_mc), .ALUfunc(alu_mc), .imm(imm_mc), .immswitches(ims_mc),
    .reg_we(we_mc), .mul_start(ms_mc), .illegal(ill_mc)
  );

  ctrl_fsm #(.O_SIZE(6), .A_SIZE(2), .DEB_CYCLES(4), .MUL_MC(0)) dut_sc (
    .clk(clk), .reset(reset), .opcode(opcode), .SW8(SW8), .mul_done(mul_done),
    .PCincr(pc_sc), .ALUfunc(alu_sc), .imm(imm_sc), .immswitches(ims_sc),
    .reg_we(we_sc), .mul_start(ms_sc), .illegal(ill_sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         mc;
    logic [7:0] exp;
  } item_t;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  logic [7:0] out_mc, out_sc;
  assign out_mc = {pc_mc, alu_mc, imm_mc, ims_mc, we_mc, ms_mc, ill_mc};
  assign out_sc = {pc_sc, alu_sc, imm_sc, ims_sc, we_sc, ms_sc, ill_sc};

  // Monitor: every expectation queued during a cycle is checked on the
  // following falling edge, away from the active edge.
  item_t      mon_it;
  logic [7:0] mon_got;
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      mon_it  = sbq.pop_front();
      mon_got = mon_it.mc ? out_mc : out_sc;
      checks++;
      if (mon_got !== mon_it.exp) begin
        errors++;
        $display("FAIL %s dut=%s got=%b want=%b", mon_it.name,
                 mon_it.mc ? "mc" : "sc", mon_got, mon_it.exp);
      end
    end
  end

  function automatic logic [7:0] mk(bit pc, logic [1:0] alu, bit im, bit ims,
                                    bit we, bit ms, bit il);
    return {pc, alu, im, ims, we, ms, il};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect1(string n, bit mc, logic [7:0] v);
    item_t it;
    it.name = n;
    it.mc   = mc;
    it.exp  = v;
    sbq.push_back(it);
  endtask

  task automatic expect2(string n, logic [7:0] v_sc, logic [7:0] v_mc);
    expect1(n, 1'b0, v_sc);
    expect1(n, 1'b1, v_mc);
  endtask

  logic [7:0] v;

  initial begin
    reset    = 1'b1;
    opcode   = ADDI;
    SW8      = 1'b0;
    mul_done = 1'b0;
    step();
    step();

    // Reset held with ADDI on the bus: all defaults.
    v = mk(0, RA, 0, 0, 0, 0, 0);
    expect2("rst_addi", v, v);
    step();
    reset = 1'b0;
    v = mk(1, RADD, 1, 0, 1, 0, 0);
    expect2("addi", v, v);
    step();

    opcode = LIR;   v = mk(1, RB, 1, 0, 1, 0, 0);   expect2("lir", v, v);   step();
    opcode = ADD;   v = mk(1, RADD, 0, 0, 1, 0, 0); expect2("add", v, v);   step();
    opcode = LSR;   v = mk(0, RB, 1, 1, 0, 0, 0);   expect2("lsr_sw0", v, v); step();
    opcode = WAIT0; v = mk(1, RA, 0, 0, 0, 0, 0);   expect2("wait0_sw0", v, v); step();
    opcode = WAIT1; v = mk(0, RA, 0, 0, 0, 0, 0);   expect2("wait1_sw0", v, v); step();

    // SW8 0->1 held: first sampled at the next edge, accepted 6 edges later.
    SW8 = 1'b1;
    v = mk(0, RA, 0, 0, 0, 0, 0);
    expect2("deb_c0", v, v);
    step();
    for (int i = 1; i <= 6; i++) begin
      v = mk(i == 6, RA, 0, 0, 0, 0, 0);
      expect2($sformatf("deb_edge%0d", i), v, v);
      step();
    end
    opcode = LSR;   v = mk(1, RB, 1, 1, 1, 0, 0); expect2("lsr_sw1", v, v);   step();
    opcode = WAIT0; v = mk(0, RA, 0, 0, 0, 0, 0); expect2("wait0_sw1", v, v); step();

    // Return SW8 to 0 and let it settle.
    SW8 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    v = mk(1, RA, 0, 0, 0, 0, 0);
    expect2("wait0_back0", v, v);
    step();

    // A 3-cycle pulse must never be accepted.
    opcode = WAIT1;
    v = mk(0, RA, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      SW8 = (i < 3);
      expect2($sformatf("pulse_c%0d", i), v, v);
      step();
    end

    // MULI with multi-cycle handshake; mul_done high in cycle 0 is ignored.
    opcode   = MULI;
    mul_done = 1'b1;
    expect2("muli_c0", mk(1, RMUL, 1, 0, 1, 0, 0), mk(0, RMUL, 1, 0, 0, 1, 0));
    step();
    mul_done = 1'b0;
    expect2("muli_c1", mk(1, RMUL, 1, 0, 1, 0, 0), mk(0, RMUL, 1, 0, 0, 0, 0));
    step();
    expect2("muli_c2", mk(1, RMUL, 1, 0, 1, 0, 0), mk(0, RMUL, 1, 0, 0, 0, 0));
    step();
    mul_done = 1'b1;
    expect2("muli_c3", mk(1, RMUL, 1, 0, 1, 0, 0), mk(1, RMUL, 1, 0, 1, 0, 0));
    step();
    // mul_done still high, back in EXEC with a new instruction.
    opcode = ADD;
    v = mk(1, RADD, 0, 0, 1, 0, 0);
    expect2("after_mul", v, v);
    step();

    // MUL, then reset during MULWAIT cycle 2.
    opcode   = MUL;
    mul_done = 1'b0;
    expect2("mul_c0", mk(1, RMUL, 0, 0, 1, 0, 0), mk(0, RMUL, 0, 0, 0, 1, 0));
    step();
    expect2("mul_c1", mk(1, RMUL, 0, 0, 1, 0, 0), mk(0, RMUL, 0, 0, 0, 0, 0));
    step();
    reset = 1'b1;
    v = mk(0, RA, 0, 0, 0, 0, 0);
    expect2("mul_rst", v, v);
    step();
    reset  = 1'b0;
    opcode = ADD;
    v = mk(1, RADD, 0, 0, 1, 0, 0);
    expect2("post_rst_add", v, v);
    step();

    // Undefined opcode: sticky halt.
    opcode = BADOP;
    v = mk(0, RA, 0, 0, 0, 0, 0);
    expect2("bad_c0", v, v);
    step();
    v = mk(0, RA, 0, 0, 0, 0, 1);
    expect2("bad_c1", v, v);
    step();
    opcode = ADD;
    expect2("halt_add", v, v);
    step();
    opcode = LIR;
    expect2("halt_lir", v, v);
    step();
    reset = 1'b1;
    v = mk(0, RA, 0, 0, 0, 0, 0);
    expect2("halt_rst", v, v);
    step();
    reset = 1'b0;
    v = mk(1, RB, 1, 0, 1, 0, 0);
    expect2("post_halt_lir", v, v);
    step();
    step();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
